// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the multi-cycle CPU memory stage.
// Provides data widths, the responder FSM state encoding and the size-select encoding.
// It also provides a helper that widens a loaded byte to a full word.
package cpu_mem_pkg;

    localparam int WORD_W = 16;
    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    // byte_or_word encoding
    localparam logic SZ_WORD = 1'b0;
    localparam logic SZ_BYTE = 1'b1;

    // Widen a loaded byte to a word, either sign- or zero-extended
    function automatic logic [WORD_W-1:0] extend_byte(input logic [BYTE_W-1:0] b,
                                                      input logic              sign_ext);
        logic [WORD_W-1:0] res;
        if (sign_ext) begin
            res = {{BYTE_W{b[BYTE_W-1]}}, b};
        end else begin
            res = {{BYTE_W{1'b0}}, b};
        end
        return res;
    endfunction

endpackage

// File: rtl/data_mem_array.sv
// Byte-wide data RAM used by data_mem_responder.
// Two asynchronous byte read ports (lo/hi) and one synchronous 16-bit write port.
// The write port has a 2-bit byte enable and addresses one aligned byte pair.
// Contents are never reset.
// Ports:
//   clk       in   rising-edge clock
//   we        in   write strobe
//   be[1:0]   in   byte enables; bit0 = even byte, bit1 = odd byte of the pair
//   waddr     in   byte-pair (word) index
//   wdata     in   {odd byte, even byte}
//   raddr_lo  in   byte address of read port lo
//   raddr_hi  in   byte address of read port hi
//   rdata_lo  out  byte at raddr_lo
//   rdata_hi  out  byte at raddr_hi
module data_mem_array #(
    parameter  int DEPTH_BYTES = 256,
    localparam int IDX_W       = $clog2(DEPTH_BYTES)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [1:0]       be,
    input  logic [IDX_W-2:0] waddr,
    input  logic [15:0]      wdata,
    input  logic [IDX_W-1:0] raddr_lo,
    input  logic [IDX_W-1:0] raddr_hi,
    output logic [7:0]       rdata_lo,
    output logic [7:0]       rdata_hi
);

    logic [7:0] mem [DEPTH_BYTES];

    // Byte-enabled write into the even/odd bytes of one aligned pair
    always_ff @(posedge clk) begin
        if (we) begin
            if (be[0]) begin
                mem[{waddr, 1'b0}] <= wdata[7:0];
            end
            if (be[1]) begin
                mem[{waddr, 1'b1}] <= wdata[15:8];
            end
        end
    end

    assign rdata_lo = mem[raddr_lo];
    assign rdata_hi = mem[raddr_hi];

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the MemAccess stage of the multi-cycle CPU.
// It latches a MemR/MemW request in IDLE and spends WAIT_CYCLES+1 cycles in ACCESS.
// On the ACCESS->RESP edge it commits the write or captures the read data.
// It then pulses ready for one cycle in RESP.
// Optional feature: define MISALIGN_TRAP_EN to flag word accesses at odd addresses.
// Such accesses get err=1 with ready, no write and rdata=0.
// When the macro is undefined, addr[0] is ignored for words and err stays 0.
// Ports:
//   clk, reset    clock and synchronous active-low reset
//   mem_r, mem_w  read / write request levels, held until ready
//   byte_or_word  0 = 16-bit word, 1 = byte
//   sign_ext      byte loads: 1 = sign-extend, 0 = zero-extend
//   addr          byte address, wrapped modulo DEPTH_BYTES (power of two)
//   wdata         store data; byte stores use wdata[7:0]
//   rdata         load result, held between loads
//   ready         one-cycle completion pulse
//   busy          high from accept through the ready cycle
//   err           misaligned-word flag, pulsed with ready
module data_mem_responder
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DEPTH_BYTES = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_r,
    input  logic              mem_w,
    input  logic              byte_or_word,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata,
    output logic              ready,
    output logic              busy,
    output logic              err
);

    localparam int         IDX_W     = $clog2(DEPTH_BYTES);
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic              size_q, size_d;
    logic              sext_q, sext_d;
    logic [IDX_W-1:0]  addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [WORD_W-1:0] rdata_q, rdata_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;

    logic              commit_s;
    logic              trap_s;
    logic              we_s;
    logic [1:0]        be_s;
    logic [WORD_W-1:0] arr_wdata_s;
    logic [IDX_W-1:0]  lo_addr_s;
    logic [IDX_W-1:0]  hi_addr_s;
    logic [BYTE_W-1:0] lo_byte_s;
    logic [BYTE_W-1:0] hi_byte_s;
    logic              unused_addr_hi_s;

    // Upper address bits are discarded by the modulo-DEPTH_BYTES wrap
    assign unused_addr_hi_s = ^addr[ADDR_W-1:IDX_W];

`ifdef MISALIGN_TRAP_EN
    assign trap_s = (size_q == SZ_WORD) && addr_q[0];
`else
    assign trap_s = 1'b0;
`endif

    assign commit_s = (state_q == ACCESS) && (cnt_q == WAIT_LAST);
    // The reset qualifier drops a write whose commit edge coincides with reset
    assign we_s     = commit_s && wr_q && !trap_s && reset;

    // Word accesses use the aligned pair, so the word at DEPTH-1 aligns down to DEPTH-2.
    // Byte accesses read the addressed byte on the lo port.
    always_comb begin
        hi_addr_s = {addr_q[IDX_W-1:1], 1'b1};
        if (size_q == SZ_WORD) begin
            lo_addr_s   = {addr_q[IDX_W-1:1], 1'b0};
            be_s        = 2'b11;
            arr_wdata_s = wdata_q;
        end else begin
            lo_addr_s   = addr_q;
            be_s        = addr_q[0] ? 2'b10 : 2'b01;
            arr_wdata_s = {wdata_q[BYTE_W-1:0], wdata_q[BYTE_W-1:0]};
        end
    end

    data_mem_array #(
        .DEPTH_BYTES(DEPTH_BYTES)
    ) u_array (
        .clk      (clk),
        .we       (we_s),
        .be       (be_s),
        .waddr    (addr_q[IDX_W-1:1]),
        .wdata    (arr_wdata_s),
        .raddr_lo (lo_addr_s),
        .raddr_hi (hi_addr_s),
        .rdata_lo (lo_byte_s),
        .rdata_hi (hi_byte_s)
    );

    // Next-state and next-output computation for the responder FSM
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        size_d  = size_q;
        sext_d  = sext_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        busy_d  = busy_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_r || mem_w) begin
                    state_d = ACCESS;
                    cnt_d   = 4'd0;
                    wr_d    = mem_w;      // write wins when both are high
                    size_d  = byte_or_word;
                    sext_d  = sign_ext;
                    addr_d  = addr[IDX_W-1:0];
                    wdata_d = wdata;
                    busy_d  = 1'b1;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            ACCESS: begin
                if (commit_s) begin
                    state_d = RESP;
                    ready_d = 1'b1;
                    err_d   = trap_s;
                    if (trap_s) begin
                        rdata_d = {WORD_W{1'b0}};
                    end else if (wr_q) begin
                        rdata_d = rdata_q;
                    end else if (size_q == SZ_WORD) begin
                        rdata_d = {hi_byte_s, lo_byte_s};
                    end else begin
                        rdata_d = extend_byte(lo_byte_s, sext_q);
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // FSM state and registered outputs, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            size_q  <= SZ_WORD;
            sext_q  <= 1'b0;
            addr_q  <= {IDX_W{1'b0}};
            wdata_q <= {WORD_W{1'b0}};
            rdata_q <= {WORD_W{1'b0}};
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            sext_q  <= sext_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign rdata = rdata_q;
    assign ready = ready_q;
    assign busy  = busy_q;
    assign err   = err_q;

endmodule
